lfsr_trigger_seq: RTL and testbench



---
 rtl/lfsr_trigger_seq.sv | 99 +++++++++
 tb/tb_lfsr_trigger_seq.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_trigger_seq.sv
// Trigger-qualified 20-bit Fibonacci LFSR (x^20+x^17+1). It arms on the word sequence PATTERN_A, PATTERN_B.
// Defining LFSR_TRIG_TIMEOUT_EN bounds the RUN window to RUN_LEN cycles; otherwise RUN holds until rst.
module lfsr_trigger_seq #(
  parameter logic [127:0] PATTERN_A = 128'h00112233445566778899AABBCCDDEEFF,
  parameter logic [127:0] PATTERN_B = 128'h3243F6A8885A308D313198A2E0370734,
  parameter logic [19:0]  SEED      = 20'h00001,
  parameter logic [19:0]  RUN_LEN   = 20'd1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] data,
  input  logic         data_valid,
  output logic [19:0]  counter,
  output logic         active,
  output logic [1:0]   state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GOT_A = 2'd1,
    RUN   = 2'd2
  } state_t;

  // An all-zero seed would lock the LFSR, so it is forced to 1.
  localparam logic [19:0] SEED_EFF = (SEED == 20'd0) ? 20'h00001 : SEED;

  state_t      state_q, state_d;
  logic [19:0] counter_q, counter_d;
  logic        active_q, active_d;
  logic        match_a, match_b, fb;

  assign match_a = data_valid && (data == PATTERN_A);
  assign match_b = data_valid && (data == PATTERN_B);
  assign fb      = counter_q[19] ^ counter_q[16];

`ifdef LFSR_TRIG_TIMEOUT_EN
  localparam logic [19:0] RUN_LAST = (RUN_LEN == 20'd0) ? 20'd0 : RUN_LEN - 20'd1;
  logic [19:0] run_cnt_q, run_cnt_d;
`else
  logic unused_run_len;
  assign unused_run_len = ^RUN_LEN;
`endif

  always_comb begin
    state_d   = state_q;
    counter_d = SEED_EFF;
    case (state_q)
      IDLE: begin
        if (match_a) state_d = GOT_A;
      end
      GOT_A: begin
        // B is tested first so that identical patterns still arm.
        if (match_b)         state_d = RUN;
        else if (match_a)    state_d = GOT_A;
        else if (data_valid) state_d = IDLE;
      end
      RUN: begin
        counter_d = {counter_q[18:0], fb};
`ifdef LFSR_TRIG_TIMEOUT_EN
        if (run_cnt_q == RUN_LAST) begin
          state_d   = IDLE;
          counter_d = SEED_EFF;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    active_d = (state_d == RUN);
  end

`ifdef LFSR_TRIG_TIMEOUT_EN
  always_comb begin
    run_cnt_d = 20'd0;
    if (state_q == RUN && state_d == RUN) run_cnt_d = run_cnt_q + 20'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) run_cnt_q <= 20'd0;
    else     run_cnt_q <= run_cnt_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      counter_q <= SEED_EFF;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      active_q  <= active_d;
    end
  end

  assign counter = counter_q;
  assign active  = active_q;
  assign state   = state_q;

endmodule

// File: tb/tb_lfsr_trigger_seq.sv
// Directed bench for lfsr_trigger_seq; also builds a SEED=0 instance to check the seed substitution.
module tb_lfsr_trigger_seq;

  localparam logic [127:0] PAT_A = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] PAT_B = 128'h3243F6A8885A308D313198A2E0370734;
  localparam logic [127:0] JUNK  = 128'hDEADBEEF_00000000_12345678_9ABCDEF0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] data = '0;
  logic         data_valid = 1'b0;
  logic [19:0]  counter, counter0;
  logic         active, active0;
  logic [1:0]   state, state0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lfsr_trigger_seq #(.SEED(20'h00001), .RUN_LEN(20'd4)) dut (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .counter(counter), .active(active), .state(state)
  );

  lfsr_trigger_seq #(.SEED(20'h00000), .RUN_LEN(20'd4)) dut_seed0 (
    .clk(clk), .rst(rst), .data(data), .data_valid(data_valid),
    .counter(counter0), .active(active0), .state(state0)
  );

  // Present one word, clock it in, and sample 1 ns after the edge.
  task automatic step(input logic [127:0] d, input logic v);
    data = d;
    data_valid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    data = '0;
    data_valid = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (counter0 !== 20'h00001) begin
      miscompares++;
      $display("FAIL seed0_reset: counter=%h expected 00001", counter0);
    end
    for (int i = 0; i < 100; i++) begin
      step('0, 1'b0);
      vectors++;
      if (counter !== 20'h00001 || active !== 1'b0 || state !== 2'd0) begin
        miscompares++;
        $display("FAIL reset_idle cycle %0d: counter=%h active=%b state=%0d expected 00001/0/0",
                 i, counter, active, state);
      end
    end
  endtask

  task automatic test_sequence();
    logic [19:0] exp_tab [21];
    for (int i = 0; i < 17; i++) exp_tab[i] = 20'h00001 << i;
    exp_tab[17] = 20'h20001;
    exp_tab[18] = 20'h40002;
    exp_tab[19] = 20'h80004;
    exp_tab[20] = 20'h00009;
    step(PAT_A, 1'b1);
    vectors++;
    if (state !== 2'd1 || active !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_got_a: state=%0d active=%b expected 1/0", state, active);
    end
    step(PAT_B, 1'b1);
    for (int i = 0; i < 21; i++) begin
      if (i > 0) step('0, 1'b0);
      vectors++;
      if (counter !== exp_tab[i] || active !== 1'b1 || state !== 2'd2) begin
        miscompares++;
        $display("FAIL seq_lfsr step %0d: counter=%h active=%b state=%0d expected %h/1/2",
                 i, counter, active, state, exp_tab[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    #3;
    rst = 1'b1;
    #1;
    vectors++;
    if (active !== 1'b0 || counter !== 20'h00001 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL async_reset: counter=%h active=%b state=%0d expected 00001/0/0",
               counter, active, state);
    end
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_bubbles();
    do_reset();
    step(PAT_A, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(JUNK, 1'b0);
      vectors++;
      if (state !== 2'd1) begin
        miscompares++;
        $display("FAIL bubble_hold %0d: state=%0d expected 1", i, state);
      end
    end
    step(PAT_B, 1'b1);
    vectors++;
    if (active !== 1'b1 || state !== 2'd2 || counter !== 20'h00001) begin
      miscompares++;
      $display("FAIL bubble_arm: counter=%h active=%b state=%0d expected 00001/1/2",
               counter, active, state);
    end
  endtask

  task automatic test_break();
    do_reset();
    step(PAT_A, 1'b1);
    step(JUNK, 1'b1);
    vectors++;
    if (state !== 2'd0) begin
      miscompares++;
      $display("FAIL break_idle: state=%0d expected 0", state);
    end
    step(PAT_B, 1'b1);
    vectors++;
    if (active !== 1'b0 || state !== 2'd0) begin
      miscompares++;
      $display("FAIL break_no_arm: active=%b state=%0d expected 0/0", active, state);
    end
  endtask

  task automatic test_aab();
    do_reset();
    step(PAT_A, 1'b1);
    step(PAT_A, 1'b1);
    vectors++;
    if (state !== 2'd1 || active !== 1'b0) begin
      miscompares++;
      $display("FAIL aab_hold: state=%0d active=%b expected 1/0", state, active);
    end
    step(PAT_B, 1'b1);
    vectors++;
    if (active !== 1'b1 || state !== 2'd2 || counter !== 20'h00001) begin
      miscompares++;
      $display("FAIL aab_arm: counter=%h active=%b state=%0d expected 00001/1/2",
               counter, active, state);
    end
  endtask

  task automatic test_run_window();
    logic [19:0] exp_c [4];
    exp_c[0] = 20'h00001;
    exp_c[1] = 20'h00002;
    exp_c[2] = 20'h00004;
    exp_c[3] = 20'h00008;
    do_reset();
    step(PAT_A, 1'b1);
    step(PAT_B, 1'b1);
`ifdef LFSR_TRIG_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step('0, 1'b0);
      vectors++;
      if (active !== 1'b1 || counter !== exp_c[i]) begin
        miscompares++;
        $display("FAIL timeout_window %0d: counter=%h active=%b expected %h/1",
                 i, counter, active, exp_c[i]);
      end
    end
    step('0, 1'b0);
    vectors++;
    if (active !== 1'b0 || state !== 2'd0 || counter !== 20'h00001) begin
      miscompares++;
      $display("FAIL timeout_end: counter=%h active=%b state=%0d expected 00001/0/0",
               counter, active, state);
    end
    step(PAT_A, 1'b1);
    step(PAT_B, 1'b1);
    vectors++;
    if (active !== 1'b1 || state !== 2'd2 || counter !== 20'h00001) begin
      miscompares++;
      $display("FAIL timeout_rearm: counter=%h active=%b state=%0d expected 00001/1/2",
               counter, active, state);
    end
`else
    for (int i = 0; i < 4; i++) begin
      if (i > 0) step('0, 1'b0);
      vectors++;
      if (active !== 1'b1 || counter !== exp_c[i]) begin
        miscompares++;
        $display("FAIL run_start %0d: counter=%h active=%b expected %h/1",
                 i, counter, active, exp_c[i]);
      end
    end
    for (int i = 0; i < 5000; i++) step(JUNK, i[0]);
    vectors++;
    if (active !== 1'b1 || state !== 2'd2) begin
      miscompares++;
      $display("FAIL run_terminal: active=%b state=%0d expected 1/2", active, state);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_async_reset();
    test_bubbles();
    test_break();
    test_aab();
    test_run_window();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
